// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================
// Module   : core_pkg
// Brief    : Shared RV32I core types and constants.
// Revision : 1.0
// ============================================================
package core_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================
// Module   : fetch_stage_if
// Brief    : Instruction-memory request/response channel.
// Revision : 1.0
// ============================================================
interface fetch_stage_if;
    import core_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================
// Module   : if_id_reg
// Brief    : Generic pipeline register; flush beats hold beats load.
// Revision : 1.0
// ============================================================
module if_id_reg #(
    parameter int                DATA_W     = 32,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_load,
    input  wire logic              i_flush,
    input  wire logic              i_hold,
    input  wire logic [DATA_W-1:0] i_data,
    output logic                   o_valid,
    output logic [DATA_W-1:0]      o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= RESET_DATA;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            if (i_load) begin
                r_valid <= 1'b1;
                r_data  <= i_data;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================
// Module   : fetch_stage
// Brief    : RV32I instruction fetch: PC, imem handshake, IF/ID.
// Revision : 1.0
// ============================================================
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    fetch_stage_if.master        imem,
    input  wire logic            stall,
    input  wire logic            br_taken,
    input  wire logic [XLEN-1:0] br_target,
    output logic                 ifid_valid,
    output logic [XLEN-1:0]      ifid_pc,
    output logic [XLEN-1:0]      ifid_instr,
    output logic [XLEN-1:0]      ifid_pc_plus4
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_br_pc;
    logic [XLEN-1:0] r_hold_instr;
    logic            w_hold_we;
    logic            w_load;
    logic            w_load_buf;
    logic            w_handshake;
    logic            w_can_load;
    logic [3*XLEN-1:0] w_ifid_d;
    logic [3*XLEN-1:0] w_ifid_q;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_pc     = br_target & {{(XLEN-2){1'b1}}, 2'b00};
    assign w_handshake = (r_state == REQ) && imem.imem_req_ready;
    assign w_can_load  = !stall || !ifid_valid;

    assign imem.imem_req_valid = (r_state == REQ);
    assign imem.imem_req_addr  = r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_hold_instr <= INSTR_NOP;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_hold_we) begin
                r_hold_instr <= imem.imem_rsp_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_load       = 1'b0;
        w_load_buf   = 1'b0;
        w_hold_we    = 1'b0;
        case (r_state)
            IDLE: w_state_next = REQ;
            REQ: begin
                if (w_handshake) w_state_next = WAIT;
            end
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    if (w_can_load) begin
                        w_load       = 1'b1;
                        w_pc_next    = w_pc_plus4;
                        w_state_next = REQ;
                    end else begin
                        w_hold_we    = 1'b1;
                        w_state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_can_load) begin
                    w_load       = 1'b1;
                    w_load_buf   = 1'b1;
                    w_pc_next    = w_pc_plus4;
                    w_state_next = REQ;
                end
            end
            DROP: begin
                if (imem.imem_rsp_valid) w_state_next = REQ;
            end
            default: w_state_next = IDLE;
        endcase

        // Redirect overrides everything; only an in-flight request forces DROP.
        if (br_taken) begin
            w_load     = 1'b0;
            w_load_buf = 1'b0;
            w_hold_we  = 1'b0;
            w_pc_next  = w_br_pc;
            case (r_state)
                REQ:        w_state_next = w_handshake ? DROP : REQ;
                WAIT, DROP: w_state_next = imem.imem_rsp_valid ? REQ : DROP;
                default:    w_state_next = REQ;
            endcase
        end
    end

    assign w_ifid_d = {r_pc, (w_load_buf ? r_hold_instr : imem.imem_rsp_data), w_pc_plus4};

    if_id_reg #(
        .DATA_W     (3*XLEN),
        .RESET_DATA ({{XLEN{1'b0}}, INSTR_NOP, {XLEN{1'b0}}})
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (br_taken),
        .i_hold  (stall && ifid_valid),
        .i_data  (w_ifid_d),
        .o_valid (ifid_valid),
        .o_data  (w_ifid_q)
    );

    assign {ifid_pc, ifid_instr, ifid_pc_plus4} = w_ifid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================
// Module   : tb_fetch_stage
// Brief    : Directed bench for fetch_stage with stream-level model.
// Revision : 1.0
// ============================================================
module tb_fetch_stage;

    localparam logic [31:0] c_reset_pc = 32'h0000_0100;
    localparam logic [31:0] c_nop      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    fetch_stage_if u_imem ();

    fetch_stage #(.RESET_PC(c_reset_pc)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (u_imem),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus4 (ifid_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle counter: cycle 0 is the cycle in which rst_n rises.
    initial forever begin
        @(posedge clk);
        if (rst_n) cyc++;
        else       cyc = 0;
    end

    task automatic to_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Memory: one outstanding request, response mem_lat cycles after handshake.
    int          mem_lat;
    logic        mem_hs = 1'b0;
    logic [31:0] mem_hs_addr = '0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;

    initial begin
        u_imem.imem_rsp_valid = 1'b0;
        u_imem.imem_rsp_data  = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk);
            #1;
            u_imem.imem_rsp_valid = 1'b0;
            u_imem.imem_rsp_data  = 32'hBAD0_BAD0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (mem_hs) begin
                    pend      = 1'b1;
                    cnt       = mem_lat;
                    pend_addr = mem_hs_addr;
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        u_imem.imem_rsp_valid = 1'b1;
                        u_imem.imem_rsp_data  = instr_of(pend_addr);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Stream model: fetch addresses and delivered instructions follow program
    // order from the reset PC, restarting at the aligned target on redirect.
    logic [31:0] exp_fetch, exp_deliver, p_target, p_pc, p_instr, p_plus4;
    logic        p_br, p_stall, p_valid;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_fetch   = c_reset_pc;
            exp_deliver = c_reset_pc;
            p_br        = 1'b0;
            p_stall     = 1'b0;
            p_valid     = 1'b0;
            mem_hs      = 1'b0;
        end else begin
            if (p_br) begin
                chk("model_flush_valid", {31'b0, ifid_valid}, 32'd0);
                exp_deliver = p_target & 32'hFFFF_FFFC;
            end else if (p_stall && p_valid) begin
                chk("model_hold_valid", {31'b0, ifid_valid}, 32'd1);
                chk("model_hold_pc", ifid_pc, p_pc);
                chk("model_hold_instr", ifid_instr, p_instr);
                chk("model_hold_plus4", ifid_pc_plus4, p_plus4);
            end else if (ifid_valid) begin
                chk("model_pc", ifid_pc, exp_deliver);
                chk("model_instr", ifid_instr, instr_of(exp_deliver));
                chk("model_plus4", ifid_pc_plus4, exp_deliver + 32'd4);
                exp_deliver = exp_deliver + 32'd4;
            end
            mem_hs      = u_imem.imem_req_valid && u_imem.imem_req_ready;
            mem_hs_addr = u_imem.imem_req_addr;
            if (mem_hs) chk("model_fetch_addr", u_imem.imem_req_addr, exp_fetch);
            if (br_taken)    exp_fetch = br_target & 32'hFFFF_FFFC;
            else if (mem_hs) exp_fetch = exp_fetch + 32'd4;
            p_br     = br_taken;
            p_target = br_target;
            p_stall  = stall;
            p_valid  = ifid_valid;
            p_pc     = ifid_pc;
            p_instr  = ifid_instr;
            p_plus4  = ifid_pc_plus4;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        mem_lat   = 1;
        u_imem.imem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_req_valid", {31'b0, u_imem.imem_req_valid}, 32'd0);
        chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
        chk("rst_ifid_pc", ifid_pc, 32'd0);
        chk("rst_ifid_instr", ifid_instr, c_nop);
        chk("rst_ifid_plus4", ifid_pc_plus4, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk("idle_req_valid", {31'b0, u_imem.imem_req_valid}, 32'd0);

        // Sequential fetch, 2 cycles per instruction
        to_cycle(1);
        chk("c1_req_valid", {31'b0, u_imem.imem_req_valid}, 32'd1);
        chk("c1_req_addr", u_imem.imem_req_addr, 32'h100);
        to_cycle(2);
        chk("c2_req_valid", {31'b0, u_imem.imem_req_valid}, 32'd0);
        to_cycle(3);
        chk("c3_ifid_valid", {31'b0, ifid_valid}, 32'd1);
        chk("c3_ifid_pc", ifid_pc, 32'h100);
        chk("c3_ifid_instr", ifid_instr, 32'hDEAD_0100);
        chk("c3_ifid_plus4", ifid_pc_plus4, 32'h104);
        chk("c3_req_addr", u_imem.imem_req_addr, 32'h104);
        to_cycle(5);
        chk("c5_req_addr", u_imem.imem_req_addr, 32'h108);
        chk("c5_ifid_pc", ifid_pc, 32'h104);

        // Stall 3 cycles while a response arrives
        to_cycle(7);
        chk("c7_ifid_pc", ifid_pc, 32'h108);
        stall = 1'b1;
        to_cycle(9);
        chk("stall_no_req_c9", {31'b0, u_imem.imem_req_valid}, 32'd0);
        to_cycle(10);
        stall = 1'b0;
        chk("stall_no_req_c10", {31'b0, u_imem.imem_req_valid}, 32'd0);
        chk("stall_ifid_pc_c10", ifid_pc, 32'h108);
        to_cycle(11);
        chk("release_ifid_pc", ifid_pc, 32'h10C);
        chk("release_ifid_instr", ifid_instr, 32'hDEAD_010C);
        chk("release_req_addr", u_imem.imem_req_addr, 32'h110);

        // Redirect in the same cycle as a response
        to_cycle(12);
        br_taken = 1'b1; br_target = 32'h200;
        to_cycle(13);
        br_taken = 1'b0;
        chk("br_rsp_ifid_valid", {31'b0, ifid_valid}, 32'd0);
        chk("br_rsp_req_valid", {31'b0, u_imem.imem_req_valid}, 32'd1);
        chk("br_rsp_req_addr", u_imem.imem_req_addr, 32'h200);
        to_cycle(15);
        chk("br_rsp_ifid_pc", ifid_pc, 32'h200);

        // Redirect in WAIT before the response: DROP the late response
        to_cycle(17);
        mem_lat = 3;
        chk("c17_req_addr", u_imem.imem_req_addr, 32'h208);
        to_cycle(18);
        br_taken = 1'b1; br_target = 32'h400;
        to_cycle(19);
        br_taken = 1'b0;
        chk("drop_ifid_valid", {31'b0, ifid_valid}, 32'd0);
        chk("drop_req_valid_c19", {31'b0, u_imem.imem_req_valid}, 32'd0);
        to_cycle(20);
        mem_lat = 1;
        chk("drop_req_valid_c20", {31'b0, u_imem.imem_req_valid}, 32'd0);
        to_cycle(21);
        chk("drop_req_valid_c21", {31'b0, u_imem.imem_req_valid}, 32'd1);
        chk("drop_req_addr", u_imem.imem_req_addr, 32'h400);

        // Redirect and stall together, misaligned target
        to_cycle(23);
        chk("c23_ifid_pc", ifid_pc, 32'h400);
        stall = 1'b1; br_taken = 1'b1; br_target = 32'h203;
        to_cycle(24);
        stall = 1'b0; br_taken = 1'b0;
        chk("br_stall_ifid_valid", {31'b0, ifid_valid}, 32'd0);
        to_cycle(25);
        chk("br_align_req_valid", {31'b0, u_imem.imem_req_valid}, 32'd1);
        chk("br_align_req_addr", u_imem.imem_req_addr, 32'h200);

        // Not ready for 4 cycles, then redirect while still not ready
        to_cycle(27);
        chk("c27_ifid_pc", ifid_pc, 32'h200);
        chk("c27_req_addr", u_imem.imem_req_addr, 32'h204);
        u_imem.imem_req_ready = 1'b0;
        to_cycle(30);
        chk("nr_req_valid", {31'b0, u_imem.imem_req_valid}, 32'd1);
        chk("nr_req_addr", u_imem.imem_req_addr, 32'h204);
        to_cycle(31);
        br_taken = 1'b1; br_target = 32'h300;
        to_cycle(32);
        br_taken = 1'b0;
        chk("nr_br_req_addr", u_imem.imem_req_addr, 32'h300);
        chk("nr_br_ifid_valid", {31'b0, ifid_valid}, 32'd0);
        u_imem.imem_req_ready = 1'b1;

        // PC wrap at the top of the address space
        to_cycle(34);
        chk("c34_ifid_pc", ifid_pc, 32'h300);
        br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
        to_cycle(35);
        br_taken = 1'b0;
        to_cycle(36);
        chk("wrap_req_addr", u_imem.imem_req_addr, 32'hFFFF_FFFC);
        to_cycle(38);
        chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_ifid_plus4", ifid_pc_plus4, 32'h0000_0000);
        chk("wrap_req_addr_next", u_imem.imem_req_addr, 32'h0000_0000);

        // Asynchronous reset mid-transaction
        to_cycle(41);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", {31'b0, u_imem.imem_req_valid}, 32'd0);
        chk("arst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
        chk("arst_ifid_instr", ifid_instr, c_nop);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        to_cycle(1);
        chk("rerst_req_addr", u_imem.imem_req_addr, 32'h100);
        chk("rerst_req_valid", {31'b0, u_imem.imem_req_valid}, 32'd1);
        to_cycle(3);
        chk("rerst_ifid_pc", ifid_pc, 32'h100);
        to_cycle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
